nv_mem_ctrl: RTL

- PMU-side initiator for the non-volatile memory interface. It accepts single-word write and burst-read requests over a valid/ready request channel.
- It sequences the NV memory port: write strobe, address and write data out; registered read data in with one-cycle latency.
- Read data and write acknowledges are returned on a valid/ready response channel with backpressure.
- It sits between the PMU command logic and nv_memory.

---
 rtl/nv_mem_pkg.sv | 7 +
 rtl/nv_mem_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/nv_mem_pkg.sv
// nv_mem_pkg: state encoding and default widths shared by nv_mem_ctrl
package nv_mem_pkg;
  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, RSP, VFY_ADDR, VFY_DATA} state_e;
  localparam int NVM_DATA_W = 32;
  localparam int NVM_ADDR_W = 8;
  localparam int NVM_LEN_W  = 4;
endpackage

// File: rtl/nv_mem_ctrl.sv
// nv_mem_ctrl: PMU-side NV memory initiator, single-word writes and burst reads over valid/ready channels
// Ports: req_* request channel in, rsp_* response channel out, mem_* NV memory port (registered read data),
// busy while not idle. Optional write read-back check enabled by defining NVM_WRITE_VERIFY_EN.
module nv_mem_ctrl
  import nv_mem_pkg::*;
#(
  parameter int DATA_WIDTH = NVM_DATA_W,
  parameter int ADDR_WIDTH = NVM_ADDR_W,
  parameter int LEN_WIDTH  = NVM_LEN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_last,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  mem_w,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  state_e                state_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  rsp_valid_q, rsp_last_q, rsp_err_q, mem_w_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, mem_wdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  assign req_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;
  assign mem_w     = mem_w_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // mem_addr_q doubles as the burst address register; mem_wdata_q keeps the written word for the read-back compare
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_w_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_w_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          state_q    <= req_write ? WR : RD_ADDR;
          mem_w_q    <= req_write;
          mem_addr_q <= req_addr;
          cnt_q      <= req_write ? '0 : req_len;
          if (req_write) mem_wdata_q <= req_wdata;
        end
`ifdef NVM_WRITE_VERIFY_EN
        WR:       state_q <= VFY_ADDR;
        VFY_ADDR: state_q <= VFY_DATA;
        VFY_DATA: begin
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
          rsp_last_q  <= 1'b1;
          rsp_rdata_q <= mem_rdata;
          rsp_err_q   <= mem_rdata != mem_wdata_q;
        end
`else
        WR: begin
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
          rsp_last_q  <= 1'b1;
          rsp_rdata_q <= '0;
        end
`endif
        RD_ADDR: state_q <= RD_DATA;
        RD_DATA: begin
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
          rsp_last_q  <= cnt_q == '0;
          rsp_rdata_q <= mem_rdata;
        end
        RSP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          state_q     <= rsp_last_q ? IDLE : RD_ADDR;
          if (!rsp_last_q) begin
            mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
            cnt_q      <= cnt_q - LEN_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
